moore: RTL and testbench
========================

MOORE -- requirements
Module: moore

Interface
REQ-001 Port order SHALL be positional: data, clk, rst, out.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-low (rst==0 at a clk rising edge resets).
REQ-004 data  input  1  serial bit stream, one bit sampled per clk rising edge.
REQ-005 out  output  1  detect flag, driven from the current state only.
REQ-006 No parameters; no other ports.

Function
REQ-007 Block SHALL be a Moore FSM detecting serial pattern 1-0-0-1 (first bit earliest), overlapping detection allowed.
REQ-008 States SHALL be:
- S0: idle, no prefix
- S1: seen "1"
- S2: seen "10"
- S3: seen "100"
- S4: seen "1001", detect
REQ-009 State register SHALL be 3 bits with one-hot-free binary encoding S0=0 through S4=4.
REQ-010 Transitions at each rising edge with rst==1 SHALL be (data=0 / data=1):
- S0 -> S0 / S1
- S1 -> S2 / S1
- S2 -> S3 / S1
- S3 -> S0 / S4
- S4 -> S2 / S1
REQ-011 Overlap rule: the final 1 of a match SHALL count as the first 1 of the next candidate, so S4 on data=0 SHALL go to S2.
REQ-012 Unused encodings 5-7 SHALL transition to S0 on the next edge with out=0.
REQ-013 out SHALL be 1 iff state==S4, else 0, as a pure decode of the state register with no data-to-out combinational path.
REQ-014 Latency: out SHALL rise in the cycle immediately after the edge that samples the final 1 and SHALL stay high exactly one cycle unless re-entering S4.
REQ-015 S4 SHALL only be re-entered after a further full 0-0-1 suffix, so out SHALL never be high on two consecutive cycles.
REQ-016 data SHALL be sampled only at rising edges; changes between edges SHALL have no effect.

Reset
REQ-017 rst==0 at a rising edge SHALL force state to S0 regardless of data or current state; out SHALL be 0 from that edge.
REQ-018 Reset SHALL take priority over any transition, including mid-pattern and while in S4.
REQ-019 There SHALL be no asynchronous reset path; rst changes between edges SHALL have no effect until the next edge.
REQ-020 After rst returns to 1, pattern matching SHALL begin fresh from S0 with no carried prefix.
REQ-021 data SHALL be ignored, including X/unknown values, during reset edges.

Verification
REQ-022 Basic match: reset, then data 1,0,0,1 on four edges -> out=0 after edges 1-3, out=1 after edge 4, out=0 after edge 5 with data=0.
REQ-023 Overlap: data 1,0,0,1,0,0,1 -> out=1 after edge 4 and after edge 7 only.
REQ-024 Non-match with prefix reuse:
- data 1,1,0,0,1 -> out=1 only after edge 5
- data 1,0,1,0,0,1 -> out=1 only after edge 6
REQ-025 Broken prefixes: data 1,0,0,0,1 and 0,0,0,1 -> out stays 0 throughout.
REQ-026 Reset mid-operation: apply 1,0,0, then rst=0 for one edge, then data 1 -> out stays 0; then in S4, assert rst=0 -> out=0 after that edge.
REQ-027 Reset asynchrony check: pulse rst low between edges only -> no state change, out unaffected.

Source files
------------

// File: rtl/moore.sv
// Moore FSM detecting the serial pattern 1-0-0-1 on `data`, overlapping matches allowed.
// `out` is a pure decode of the state register, so it lags the final sampled 1 by one edge.
module moore (
  input  logic data,
  input  logic clk,
  input  logic rst,
  output logic out
);

  typedef enum logic [2:0] {
    S0 = 3'd0,
    S1 = 3'd1,
    S2 = 3'd2,
    S3 = 3'd3,
    S4 = 3'd4
  } state_t;

  state_t state_q, state_d;

  always_ff @(posedge clk) begin
    if (!rst) state_q <= S0;
    else      state_q <= state_d;
  end

  // Each state names the longest suffix of the input that is still a prefix of 1001.
  always_comb begin
    state_d = S0;
    unique case (state_q)
      S0:      state_d = data ? S1 : S0;
      S1:      state_d = data ? S1 : S2;
      S2:      state_d = data ? S1 : S3;
      S3:      state_d = data ? S4 : S0;
      S4:      state_d = data ? S1 : S2;
      default: state_d = S0;
    endcase
  end

  assign out = (state_q == S4);

endmodule

// File: tb/tb_moore.sv
// Bench for moore: directed sequences with literal expectations plus random stimulus
// checked every cycle against a model that looks at the last four sampled bits.
module tb_moore;

  logic data, clk, rst, out;
  int errors = 0;
  int checks = 0;

  moore dut (.data(data), .clk(clk), .rst(rst), .out(out));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: out after an edge is 1 iff the last four bits sampled since reset read 1,0,0,1.
  logic [3:0] hist = 4'd0;
  int         nbits = 0;
  bit         model_valid = 1'b0;
  bit         exp_out;
  bit         prev_out = 1'b0;

  always @(posedge clk) begin
    if (rst !== 1'b1) begin
      hist = 4'd0;
      nbits = 0;
      model_valid = 1'b1;
    end else begin
      hist = {hist[2:0], data};
      if (nbits < 4) nbits++;
    end
    exp_out = (nbits >= 4) && (hist == 4'b1001);
  end

  always @(negedge clk) begin
    if (model_valid) begin
      checks++;
      if (out !== exp_out) begin
        errors++;
        $display("FAIL model_cmp t=%0t out=%b expected=%b", $time, out, exp_out);
      end
      checks++;
      if (prev_out && out === 1'b1) begin
        errors++;
        $display("FAIL no_back_to_back t=%0t out=%b expected=0", $time, out);
      end
      prev_out = (out === 1'b1);
    end
  end

  task automatic step(input logic d, input logic r, input int exp);
    data = d;
    rst  = r;
    @(posedge clk);
    #1;
    if (exp >= 0) begin
      checks++;
      if (out !== exp[0]) begin
        errors++;
        $display("FAIL literal t=%0t data=%b rst=%b out=%b expected=%0d", $time, d, r, out, exp);
      end
    end
  endtask

  // Bits are listed earliest-first: d[n-1] is driven on the first edge.
  task automatic seq(input int n, input logic [15:0] d, input logic [15:0] e);
    for (int i = 0; i < n; i++) step(d[n-1-i], 1'b1, int'(e[n-1-i]));
  endtask

  task automatic do_reset();
    step(1'b1, 1'b0, 0);
  endtask

  initial begin
    data = 1'b0;
    rst  = 1'b0;
    do_reset();
    do_reset();

    // Basic match, then one more 0
    seq(5, 16'b10010, 16'b00010);
    // Overlapping matches
    do_reset();
    seq(7, 16'b1001001, 16'b0001001);
    // Prefix reuse
    do_reset();
    seq(5, 16'b11001, 16'b00001);
    do_reset();
    seq(6, 16'b101001, 16'b000001);
    // Broken prefixes
    do_reset();
    seq(5, 16'b10001, 16'b00000);
    do_reset();
    seq(4, 16'b0001, 16'b0000);

    // Reset mid-pattern drops the carried "100" prefix
    do_reset();
    seq(3, 16'b100, 16'b000);
    step(1'bx, 1'b0, 0);
    step(1'b1, 1'b1, 0);
    // Reach S4, then reset while in S4
    seq(3, 16'b001, 16'b001);
    step(1'b0, 1'b0, 0);
    seq(4, 16'b1001, 16'b0001);

    // rst pulses low between edges only: "100" prefix survives, completes on next 1
    do_reset();
    seq(3, 16'b100, 16'b000);
    #1 rst = 1'b0;
    #2 rst = 1'b1;
    step(1'b1, 1'b1, 1);
    // data glitches between edges are ignored
    data = 1'b1;
    #1 data = 1'b0;
    step(1'b0, 1'b1, 0);

    // Random traffic, checked each cycle by the compare process
    for (int i = 0; i < 3000; i++)
      step(1'($urandom_range(0, 1)), ($urandom_range(0, 31) == 0) ? 1'b0 : 1'b1, -1);

    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
